// File: rtl/fp_mul_arb_pkg.sv
// Shared types, constants and IEEE-754 classification helpers for the
// FP multiplier arbiter.
package fp_mul_arb_pkg;

    typedef logic [31:0] fp32_t;

    localparam int    FP_W    = 32;
    localparam fp32_t FP_ZERO = 32'h00000000;
    localparam fp32_t FP_ONE  = 32'h3F800000;
    localparam fp32_t FP_QNAN = 32'h7FC00000;
    localparam int    STAT_W  = 16;

    // Zero exponent: true zero or a denormal, both treated as zero.
    function automatic logic fp_is_zero(input fp32_t x);
        return (x[30:23] == 8'h00);
    endfunction

    function automatic logic fp_is_inf(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic fp_is_nan(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_fp_mul.sv
// FP_mul: combinational IEEE-754 single-precision multiplier.
// Round-to-nearest-even. Denormal inputs and underflowing results become +0,
// and a zero operand always gives +0. Any NaN gives the canonical quiet NaN.
// Infinity and overflow give a signed infinity.
module FP_mul
    import fp_mul_arb_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t p_o
);

    logic        sign_s;
    logic [47:0] prod_s;
    logic [22:0] mant_pre_s;
    logic        guard_s;
    logic        sticky_s;
    logic        round_up_s;
    logic [23:0] mant_rnd_s;
    logic [9:0]  exp_raw_s;
    logic [9:0]  exp_rel_s;

    assign sign_s = a_i[31] ^ b_i[31];
    assign prod_s = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};

    // Normalise the 48-bit mantissa product and pick the guard/sticky bits.
    always_comb begin
        mant_pre_s = 23'd0;
        guard_s    = 1'b0;
        sticky_s   = 1'b0;
        if (prod_s[47]) begin
            mant_pre_s = prod_s[46:24];
            guard_s    = prod_s[23];
            sticky_s   = |prod_s[22:0];
        end else begin
            mant_pre_s = prod_s[45:23];
            guard_s    = prod_s[22];
            sticky_s   = |prod_s[21:0];
        end
    end

    assign round_up_s = guard_s & (sticky_s | mant_pre_s[0]);
    assign mant_rnd_s = {1'b0, mant_pre_s} + {23'd0, round_up_s};
    // Biased sum plus normalisation and rounding carries; the bias is 127 too high.
    assign exp_raw_s  = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]}
                      + {9'd0, prod_s[47]} + {9'd0, mant_rnd_s[23]};
    assign exp_rel_s  = exp_raw_s - 10'd127;

    // Special-case selection and final packing.
    always_comb begin
        p_o = FP_ZERO;
        if (fp_is_zero(a_i) || fp_is_zero(b_i)) begin
            p_o = FP_ZERO;
        end else if (fp_is_nan(a_i) || fp_is_nan(b_i)) begin
            p_o = FP_QNAN;
        end else if (fp_is_inf(a_i) || fp_is_inf(b_i)) begin
            p_o = {sign_s, 8'hFF, 23'd0};
        end else if (exp_raw_s >= 10'd382) begin
            p_o = {sign_s, 8'hFF, 23'd0};
        end else if (exp_raw_s <= 10'd127) begin
            p_o = FP_ZERO;
        end else begin
            p_o = {sign_s, exp_rel_s[7:0], mant_rnd_s[22:0]};
        end
    end

endmodule

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
// The search starts at the pointer and wraps. On an advance the pointer
// moves to one past the winner. No grant is issued while rst is high.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] cand_s;
    logic           found_s;

    // Scan requests from the pointer with wraparound; the first set bit wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum_s >= (IDW+1)'(N)) begin
                sum_s = sum_s - (IDW+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDW-1:0];
            if (!found_s && !rst && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_id      = cand_s;
                found_s     = 1'b1;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Next pointer: one past the winner, only when a grant is taken.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found_s) begin
            if (gnt_id == IDW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + IDW'(1'b1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one FP_mul among NUM_REQ requesters.
// A round-robin grant in cycle 0 registers the operands into stage 1.
// The product is registered into stage 2 and returned with a one-hot tag.
// Optional per-requester grant counters are built when FP_MUL_ARB_STATS_EN
// is defined.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_gnt,
    output logic [NUM_REQ-1:0]      rsp_vld,
    output logic [31:0]             rsp_out,
    output logic                    busy
`ifdef FP_MUL_ARB_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [NUM_REQ*STAT_W-1:0] gnt_cnt
`endif
);

    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_id_s;
    logic               adv_s;
    fp32_t              sel_a_s;
    fp32_t              sel_b_s;
    fp32_t              prod_s;

    logic               s1_vld_q, s1_vld_d;
    fp32_t              s1_a_q,   s1_a_d;
    fp32_t              s1_b_q,   s1_b_d;
    logic [ID_W-1:0]    s1_id_q,  s1_id_d;
    logic               s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]    s2_id_q,  s2_id_d;
    fp32_t              s2_prod_q, s2_prod_d;

    assign adv_s = |gnt_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vld),
        .advance (adv_s),
        .gnt     (gnt_s),
        .gnt_id  (gnt_id_s)
    );

    assign sel_a_s = req_a[{gnt_id_s, 5'd0} +: 32];
    assign sel_b_s = req_b[{gnt_id_s, 5'd0} +: 32];

    FP_mul u_fp_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (prod_s)
    );

    // Stage next-state: capture the winner, then its product; hold when idle.
    always_comb begin
        s1_vld_d  = adv_s;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_id_d   = s1_id_q;
        s2_vld_d  = s1_vld_q;
        s2_id_d   = s1_id_q;
        s2_prod_d = s2_prod_q;
        if (adv_s) begin
            s1_a_d  = sel_a_s;
            s1_b_d  = sel_b_s;
            s1_id_d = gnt_id_s;
        end else begin
            s1_id_d = s1_id_q;
        end
        if (s1_vld_q) begin
            s2_prod_d = prod_s;
        end else begin
            s2_prod_d = s2_prod_q;
        end
    end

    // Pipeline registers; reset drops in-flight operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= FP_ZERO;
            s1_b_q    <= FP_ZERO;
            s1_id_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_id_q   <= '0;
            s2_prod_q <= FP_ZERO;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_id_q   <= s1_id_d;
            s2_vld_q  <= s2_vld_d;
            s2_id_q   <= s2_id_d;
            s2_prod_q <= s2_prod_d;
        end
    end

    // One-hot response tag decoded from the stage-2 id.
    always_comb begin
        rsp_vld = '0;
        if (s2_vld_q) begin
            rsp_vld[s2_id_q] = 1'b1;
        end else begin
            rsp_vld = '0;
        end
    end

    assign req_gnt = gnt_s;
    assign rsp_out = s2_prod_q;
    assign busy    = s1_vld_q | s2_vld_q;

`ifdef FP_MUL_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] cnt_q, cnt_d;

    // Grant counters: clear wins over increment, saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stats_clr) begin
                cnt_d[i*STAT_W +: STAT_W] = {STAT_W{1'b0}};
            end else if (gnt_s[i] && (cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1'b1);
            end else begin
                cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W];
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter (NUM_REQ=4).
module tb_fp_mul_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_vld = 4'b0000;
    logic [127:0] req_a = 128'd0;
    logic [127:0] req_b = 128'd0;
    logic [3:0]   req_gnt;
    logic [3:0]   rsp_vld;
    logic [31:0]  rsp_out;
    logic         busy;
`ifdef FP_MUL_ARB_STATS_EN
    logic         stats_clr = 1'b0;
    logic [63:0]  gnt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fp_mul_arbiter #(.NUM_REQ(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_a   (req_a),
        .req_b   (req_b),
        .req_gnt (req_gnt),
        .rsp_vld (rsp_vld),
        .rsp_out (rsp_out),
        .busy    (busy)
`ifdef FP_MUL_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .gnt_cnt   (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
    endtask

    task automatic test_reset();
        req_vld = 4'b0001;
        set_op(0, 32'h40000000, 32'h40400000);
        tick(); tick(); #1;
        total++; if (req_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", req_gnt, 4'b0000); end
        total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL reset_rsp_vld got=%b exp=%b", rsp_vld, 4'b0000); end
        total++; if (rsp_out !== 32'h0) begin bad++; $display("FAIL reset_rsp_out got=%h exp=%h", rsp_out, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
        req_vld = 4'b0000;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_vld = 4'b0001;
        set_op(0, 32'h40000000, 32'h40400000);
        #2;
        total++; if (req_gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=%b", req_gnt, 4'b0001); end
        tick(); req_vld = 4'b0000; #2;
        total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL single_rsp_early got=%b exp=%b", rsp_vld, 4'b0000); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=%b", busy, 1'b1); end
        tick(); #2;
        total++; if (rsp_vld !== 4'b0001) begin bad++; $display("FAIL single_rsp_vld got=%b exp=%b", rsp_vld, 4'b0001); end
        total++; if (rsp_out !== 32'h40C00000) begin bad++; $display("FAIL single_rsp_out got=%h exp=%h", rsp_out, 32'h40C00000); end
        tick(); #2;
        total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL single_rsp_pulse got=%b exp=%b", rsp_vld, 4'b0000); end
        total++; if (rsp_out !== 32'h40C00000) begin bad++; $display("FAIL single_rsp_hold got=%h exp=%h", rsp_out, 32'h40C00000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=%b", busy, 1'b0); end
        tick();
    endtask

    task automatic test_all_four();
        logic [31:0] exp_p [4];
        logic [3:0]  exp_g;
        int r;
        rst = 1'b1; tick(); rst = 1'b0;
        set_op(0, 32'h40000000, 32'h40400000); exp_p[0] = 32'h40C00000;
        set_op(1, 32'hBFC00000, 32'h40000000); exp_p[1] = 32'hC0400000;
        set_op(2, 32'h3F800000, 32'h3F800000); exp_p[2] = 32'h3F800000;
        set_op(3, 32'h3F000000, 32'h40800000); exp_p[3] = 32'h40000000;
        for (int c = 0; c < 10; c++) begin
            req_vld = (c < 8) ? 4'b1111 : 4'b0000;
            #2;
            exp_g = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            total++; if (req_gnt !== exp_g) begin bad++; $display("FAIL all4_gnt c=%0d got=%b exp=%b", c, req_gnt, exp_g); end
            if (c >= 2) begin
                r = (c - 2) % 4;
                total++; if (rsp_vld !== (4'b0001 << r)) begin bad++; $display("FAIL all4_rsp_vld c=%0d got=%b exp=%b", c, rsp_vld, 4'b0001 << r); end
                total++; if (rsp_out !== exp_p[r]) begin bad++; $display("FAIL all4_rsp_out c=%0d got=%h exp=%h", c, rsp_out, exp_p[r]); end
            end else begin
                total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL all4_rsp_early c=%0d got=%b exp=%b", c, rsp_vld, 4'b0000); end
            end
            tick();
        end
    endtask

    task automatic test_zero();
        set_op(0, 32'h00000000, 32'h4B7FFFFF);
        set_op(1, 32'h80000000, 32'h4B7FFFFF);
        req_vld = 4'b0011; #2;
        total++; if (req_gnt !== 4'b0001) begin bad++; $display("FAIL zero_gnt0 got=%b exp=%b", req_gnt, 4'b0001); end
        tick(); req_vld = 4'b0010; #2;
        total++; if (req_gnt !== 4'b0010) begin bad++; $display("FAIL zero_gnt1 got=%b exp=%b", req_gnt, 4'b0010); end
        tick(); req_vld = 4'b0000; #2;
        total++; if (rsp_vld !== 4'b0001) begin bad++; $display("FAIL zero_rsp_vld0 got=%b exp=%b", rsp_vld, 4'b0001); end
        total++; if (rsp_out !== 32'h00000000) begin bad++; $display("FAIL zero_pos got=%h exp=%h", rsp_out, 32'h00000000); end
        tick(); #2;
        total++; if (rsp_vld !== 4'b0010) begin bad++; $display("FAIL zero_rsp_vld1 got=%b exp=%b", rsp_vld, 4'b0010); end
        total++; if (rsp_out !== 32'h00000000) begin bad++; $display("FAIL zero_neg got=%h exp=%h", rsp_out, 32'h00000000); end
        tick();
    endtask

    task automatic test_wrap();
        req_vld = 4'b1000;
        set_op(3, 32'h40400000, 32'h40400000);
        #2;
        total++; if (req_gnt !== 4'b1000) begin bad++; $display("FAIL wrap_gnt3 got=%b exp=%b", req_gnt, 4'b1000); end
        tick();
        req_vld = 4'b1010;
        set_op(1, 32'h3F800000, 32'h40400000);
        set_op(3, 32'h40000000, 32'h40000000);
        #2;
        total++; if (req_gnt !== 4'b0010) begin bad++; $display("FAIL wrap_gnt1 got=%b exp=%b", req_gnt, 4'b0010); end
        tick(); req_vld = 4'b1000; #2;
        total++; if (req_gnt !== 4'b1000) begin bad++; $display("FAIL wrap_gnt3b got=%b exp=%b", req_gnt, 4'b1000); end
        total++; if (rsp_vld !== 4'b1000) begin bad++; $display("FAIL wrap_rsp3 got=%b exp=%b", rsp_vld, 4'b1000); end
        total++; if (rsp_out !== 32'h41100000) begin bad++; $display("FAIL wrap_out3 got=%h exp=%h", rsp_out, 32'h41100000); end
        tick(); req_vld = 4'b0000; #2;
        total++; if (rsp_vld !== 4'b0010) begin bad++; $display("FAIL wrap_rsp1 got=%b exp=%b", rsp_vld, 4'b0010); end
        total++; if (rsp_out !== 32'h40400000) begin bad++; $display("FAIL wrap_out1 got=%h exp=%h", rsp_out, 32'h40400000); end
        tick(); #2;
        total++; if (rsp_vld !== 4'b1000) begin bad++; $display("FAIL wrap_rsp3b got=%b exp=%b", rsp_vld, 4'b1000); end
        total++; if (rsp_out !== 32'h40800000) begin bad++; $display("FAIL wrap_out3b got=%h exp=%h", rsp_out, 32'h40800000); end
        tick();
    endtask

    task automatic test_reset_inflight();
        req_vld = 4'b0001;
        set_op(0, 32'h40000000, 32'h40400000);
        tick();
        req_vld = 4'b0010;
        set_op(1, 32'hBFC00000, 32'h40000000);
        tick();
        req_vld = 4'b0000;
        #1;
        total++; if (busy !== 1'b1 || rsp_vld !== 4'b0001) begin bad++; $display("FAIL inflight_pre got=%b/%b exp=1/0001", busy, rsp_vld); end
        rst = 1'b1;
        #1;
        total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL inflight_rsp_vld got=%b exp=%b", rsp_vld, 4'b0000); end
        total++; if (rsp_out !== 32'h0) begin bad++; $display("FAIL inflight_rsp_out got=%h exp=%h", rsp_out, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL inflight_busy got=%b exp=%b", busy, 1'b0); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (rsp_vld !== 4'b0000) begin bad++; $display("FAIL inflight_ghost c=%0d got=%b exp=%b", c, rsp_vld, 4'b0000); end
            tick();
        end
        req_vld = 4'b1010;
        set_op(1, 32'h40400000, 32'h40400000);
        #2;
        total++; if (req_gnt !== 4'b0010) begin bad++; $display("FAIL inflight_ptr got=%b exp=%b", req_gnt, 4'b0010); end
        tick(); req_vld = 4'b0000;
        tick(); #2;
        total++; if (rsp_vld !== 4'b0010) begin bad++; $display("FAIL inflight_next_vld got=%b exp=%b", rsp_vld, 4'b0010); end
        total++; if (rsp_out !== 32'h41100000) begin bad++; $display("FAIL inflight_next_out got=%h exp=%h", rsp_out, 32'h41100000); end
        tick(); #2;
        total++; if (rsp_vld !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL withdraw_quiet got=%b/%b exp=0000/0", rsp_vld, busy); end
        tick();
    endtask

`ifdef FP_MUL_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (gnt_cnt !== 64'd0) begin bad++; $display("FAIL stats_reset got=%h exp=%h", gnt_cnt, 64'd0); end
        req_vld = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        req_vld = 4'b0000;
        total++; if (gnt_cnt[47:32] !== 16'd5) begin bad++; $display("FAIL stats_five got=%h exp=%h", gnt_cnt[47:32], 16'd5); end
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        total++; if (gnt_cnt[47:32] !== 16'd0) begin bad++; $display("FAIL stats_clr got=%h exp=%h", gnt_cnt[47:32], 16'd0); end
        req_vld = 4'b0100; stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        total++; if (gnt_cnt[47:32] !== 16'd0) begin bad++; $display("FAIL stats_clr_prio got=%h exp=%h", gnt_cnt[47:32], 16'd0); end
        for (int i = 0; i < 65535; i++) tick();
        total++; if (gnt_cnt[47:32] !== 16'hFFFF) begin bad++; $display("FAIL stats_full got=%h exp=%h", gnt_cnt[47:32], 16'hFFFF); end
        tick();
        req_vld = 4'b0000;
        total++; if (gnt_cnt[47:32] !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h exp=%h", gnt_cnt[47:32], 16'hFFFF); end
        total++; if (gnt_cnt[31:0] !== 32'd0) begin bad++; $display("FAIL stats_others got=%h exp=%h", gnt_cnt[31:0], 32'd0); end
        tick(); tick(); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_zero();
        test_wrap();
        test_reset_inflight();
`ifdef FP_MUL_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
